// File: rtl/pipelined_carry_adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Purpose : combinational slice of the pipelined adder. Computes
//           {co, s} = x + y + ci for one W-bit carry chunk. One instance sits
//           in each pipeline stage of pipelined_carry_adder.
// Ports   :
//   x   in  W  chunk of operand A
//   y   in  W  chunk of operand B
//   ci  in  1  carry into the chunk
//   s   out W  chunk sum
//   co  out 1  carry out of the chunk's top bit
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] w_full;

    // Zero-extend every term so the carry out lands in bit W.
    assign w_full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    assign {co, s} = w_full;

endmodule

// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
// Purpose : WIDTH-bit unsigned adder {cout, sum} = a + b + cin, split into
//           STAGES register-separated carry chunks of CHUNK = WIDTH/STAGES bits.
//           Stage k adds chunk k using the registered carry from stage k-1.
//           Operand chunks not yet consumed travel down the pipe (skew), and
//           finished sum chunks travel alongside (de-skew), so all chunks of
//           one transaction leave together. Latency STAGES, throughput 1/cycle.
//           The whole pipe advances as a unit: when the output is stalled every
//           stage holds.
// Ports   :
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      a/b/cin valid this cycle
//   in_ready   out 1      input accepted this cycle when in_valid is high
//   a, b       in  WIDTH  unsigned operands
//   cin        in  1      carry in
//   out_valid  out 1      sum/cout valid
//   out_ready  in  1      consumer takes the result
//   sum        out WIDTH  result bits
//   cout       out 1      carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module pipelined_carry_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_param_check
        $error("pipelined_carry_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic              w_adv;
    logic [STAGES-1:0] r_vld;

    // The pipe moves only as a whole; a free or draining output slot lets it move.
    assign w_adv    = out_ready | ~r_vld[STAGES-1];
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // SW: sum bits finished after this stage; OW: operand bits still pending.
        localparam int SW = (k + 1) * CHUNK;
        localparam int OW = WIDTH - SW;

        logic [CHUNK-1:0] w_x;
        logic [CHUNK-1:0] w_y;
        logic [CHUNK-1:0] w_s;
        logic             w_ci;
        logic             w_co;
        logic [SW-1:0]    w_sum_nxt;
        logic [SW-1:0]    r_sum_p;
        logic             r_c_p;

        if (k == 0) begin : g_src
            assign w_x       = a[CHUNK-1:0];
            assign w_y       = b[CHUNK-1:0];
            assign w_ci      = cin;
            assign w_sum_nxt = w_s;
        end else begin : g_src
            assign w_x       = g_stg[k-1].g_op.r_opa_p[CHUNK-1:0];
            assign w_y       = g_stg[k-1].g_op.r_opb_p[CHUNK-1:0];
            assign w_ci      = g_stg[k-1].r_c_p;
            assign w_sum_nxt = {w_s, g_stg[k-1].r_sum_p};
        end

        adder_chunk #(
            .W (CHUNK)
        ) u_add (
            .x  (w_x),
            .y  (w_y),
            .ci (w_ci),
            .s  (w_s),
            .co (w_co)
        );

        // ---- stage k register boundary: partial sum and chunk carry ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum_p <= '0;
                r_c_p   <= 1'b0;
            end else if (w_adv) begin
                r_sum_p <= w_sum_nxt;
                r_c_p   <= w_co;
            end
        end

        // Operand chunks above this stage ride along until their stage is reached.
        if (OW > 0) begin : g_op
            logic [OW-1:0] w_opa_nxt;
            logic [OW-1:0] w_opb_nxt;
            logic [OW-1:0] r_opa_p;
            logic [OW-1:0] r_opb_p;

            if (k == 0) begin : g_osrc
                assign w_opa_nxt = a[WIDTH-1:CHUNK];
                assign w_opb_nxt = b[WIDTH-1:CHUNK];
            end else begin : g_osrc
                assign w_opa_nxt = g_stg[k-1].g_op.r_opa_p[OW+CHUNK-1:CHUNK];
                assign w_opb_nxt = g_stg[k-1].g_op.r_opb_p[OW+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_opa_p <= '0;
                    r_opb_p <= '0;
                end else if (w_adv) begin
                    r_opa_p <= w_opa_nxt;
                    r_opb_p <= w_opb_nxt;
                end
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign sum       = g_stg[STAGES-1].r_sum_p;
    assign cout      = g_stg[STAGES-1].r_c_p;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_carry_adder
// Directed and scoreboarded checks of pipelined_carry_adder in three
// configurations: 32/4 (default), 4/1 and 8/8.
// -----------------------------------------------------------------------------
module tb_pipelined_carry_adder;

    logic clk;
    logic rst_n;

    // 32-bit, 4 stages
    logic        d1_in_valid, d1_in_ready, d1_cin, d1_out_valid, d1_out_ready, d1_cout;
    logic [31:0] d1_a, d1_b, d1_sum;
    // 4-bit, 1 stage
    logic        d2_in_valid, d2_in_ready, d2_cin, d2_out_valid, d2_out_ready, d2_cout;
    logic [3:0]  d2_a, d2_b, d2_sum;
    // 8-bit, 8 stages
    logic        d3_in_valid, d3_in_ready, d3_cin, d3_out_valid, d3_out_ready, d3_cout;
    logic [7:0]  d3_a, d3_b, d3_sum;

    int n_assert = 0;
    int n_fail   = 0;

    logic [32:0] q1[$];
    logic [8:0]  q3[$];

    logic [31:0] t2_a   [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678,
                                32'h0000_00FF, 32'h00FF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    logic [31:0] t2_b   [8] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h8765_4321,
                                32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    logic        t2_c   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [32:0] t2_exp [8] = '{33'h0_0000_0002, 33'h1_0000_0000, 33'h1_0000_0001, 33'h0_9999_9999,
                                33'h0_0000_0100, 33'h0_0100_0000, 33'h0_DEAD_BEEF, 33'h1_FFFF_FFFF};

    logic [31:0] t3_a [5];
    logic [32:0] t3_e [5];

    pipelined_carry_adder #(.WIDTH(32), .STAGES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .cin(d1_cin), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .sum(d1_sum), .cout(d1_cout)
    );

    pipelined_carry_adder #(.WIDTH(4), .STAGES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .a(d2_a), .b(d2_b), .cin(d2_cin), .out_valid(d2_out_valid),
        .out_ready(d2_out_ready), .sum(d2_sum), .cout(d2_cout)
    );

    pipelined_carry_adder #(.WIDTH(8), .STAGES(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .a(d3_a), .b(d3_b), .cin(d3_cin), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready), .sum(d3_sum), .cout(d3_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scoreboard cycle for the 32/4 and 8/8 instances; inputs already driven.
    task automatic sb_step();
        logic [32:0] e1;
        logic [8:0]  e3;
        #1;
        if (d1_out_valid && d1_out_ready) begin
            if (q1.size() == 0) check("t5_d1_spurious", 64'(d1_out_valid), 64'd0);
            else begin
                e1 = q1.pop_front();
                check("t5_d1_res", {d1_cout, d1_sum}, e1);
            end
        end
        if (d1_in_valid && d1_in_ready)
            q1.push_back({1'b0, d1_a} + {1'b0, d1_b} + {32'd0, d1_cin});
        if (d3_out_valid && d3_out_ready) begin
            if (q3.size() == 0) check("t5_d3_spurious", 64'(d3_out_valid), 64'd0);
            else begin
                e3 = q3.pop_front();
                check("t5_d3_res", {d3_cout, d3_sum}, e3);
            end
        end
        if (d3_in_valid && d3_in_ready)
            q3.push_back({1'b0, d3_a} + {1'b0, d3_b} + {8'd0, d3_cin});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        d1_in_valid = 0; d1_a = '0; d1_b = '0; d1_cin = 0; d1_out_ready = 1;
        d2_in_valid = 0; d2_a = '0; d2_b = '0; d2_cin = 0; d2_out_ready = 1;
        d3_in_valid = 0; d3_a = '0; d3_b = '0; d3_cin = 0; d3_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            t3_a[i] = 32'h1111_1111 * i;
            t3_e[i] = {1'b0, t3_a[i]} + {1'b0, 32'h0F0F_0F0F} + 33'(i % 2);
        end

        // Reset state
        #2;
        check("rst_d1_vld",  d1_out_valid, 0);
        check("rst_d1_sum",  d1_sum, 0);
        check("rst_d1_cout", d1_cout, 0);
        check("rst_d1_rdy",  d1_in_ready, 1);
        check("rst_d2_vld",  d2_out_valid, 0);
        check("rst_d3_vld",  d3_out_valid, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Test 1: carry through every chunk, latency 4
        d1_in_valid = 1; d1_a = 32'hFFFF_FFFF; d1_b = 0; d1_cin = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            d1_in_valid = 0;
            if (j < 3) check("t1_lat_vld", d1_out_valid, 0);
            else       check("t1_res", {d1_out_valid, d1_cout, d1_sum}, {1'b1, 33'h1_0000_0000});
        end
        tick();
        check("t1_after", d1_out_valid, 0);

        // Test 2: 8 back-to-back vectors
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                d1_in_valid = 1; d1_a = t2_a[c]; d1_b = t2_b[c]; d1_cin = t2_c[c];
            end else begin
                d1_in_valid = 0;
            end
            tick();
            if (c >= 3 && c < 11)
                check($sformatf("t2_out%0d", c - 3), {d1_out_valid, d1_cout, d1_sum},
                      {1'b1, t2_exp[c-3]});
            else
                check("t2_idle", d1_out_valid, 0);
        end

        // Test 3: fill the pipe under backpressure, hold, release
        d1_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            d1_in_valid = 1; d1_a = t3_a[i]; d1_b = 32'h0F0F_0F0F; d1_cin = 1'(i % 2);
            tick();
        end
        d1_a = t3_a[4]; d1_b = 32'h0F0F_0F0F; d1_cin = 1'b0;
        for (int h = 0; h < 5; h++) begin
            check("t3_hold_rdy", d1_in_ready, 0);
            check("t3_hold_out", {d1_out_valid, d1_cout, d1_sum}, {1'b1, t3_e[0]});
            tick();
        end
        d1_out_ready = 1;
        #1;
        check("t3_rel_rdy", d1_in_ready, 1);
        check("t3_rel_out0", {d1_out_valid, d1_cout, d1_sum}, {1'b1, t3_e[0]});
        tick();
        d1_in_valid = 0;
        for (int j = 1; j < 5; j++) begin
            check($sformatf("t3_rel_out%0d", j), {d1_out_valid, d1_cout, d1_sum}, {1'b1, t3_e[j]});
            tick();
        end
        check("t3_drained", d1_out_valid, 0);

        // Test 4: asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            d1_in_valid = 1; d1_a = 32'hA5A5_0000 + i; d1_b = 1; d1_cin = 0;
            tick();
        end
        d1_in_valid = 0;
        check("t4_pre_vld", d1_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_vld",  d1_out_valid, 0);
        check("t4_rst_sum",  d1_sum, 0);
        check("t4_rst_cout", d1_cout, 0);
        check("t4_rst_rdy",  d1_in_ready, 1);
        tick();
        #2 rst_n = 1'b1;
        tick();
        d1_in_valid = 1; d1_a = 32'h0000_0010; d1_b = 32'h0000_0020; d1_cin = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            d1_in_valid = 0;
            if (j < 3) check("t4_post_vld", d1_out_valid, 0);
            else       check("t4_post_res", {d1_out_valid, d1_cout, d1_sum}, {1'b1, 33'h0_0000_0031});
        end
        tick();
        check("t4_post_after", d1_out_valid, 0);

        // Test 6a: WIDTH=4, STAGES=1 degenerates to a registered adder
        d2_in_valid = 1; d2_a = 4'hF; d2_b = 4'h1; d2_cin = 0;
        #1;
        check("t6_d2_rdy", d2_in_ready, 1);
        tick();
        d2_in_valid = 1; d2_a = 4'h5; d2_b = 4'h9; d2_cin = 1;
        check("t6_d2_res0", {d2_out_valid, d2_cout, d2_sum}, {1'b1, 1'b1, 4'h0});
        tick();
        d2_in_valid = 0;
        check("t6_d2_res1", {d2_out_valid, d2_cout, d2_sum}, {1'b1, 1'b0, 4'hF});
        tick();
        check("t6_d2_idle", d2_out_valid, 0);

        // Test 6b: WIDTH=8, STAGES=8 ripple through 1-bit chunks, latency 8
        d3_in_valid = 1; d3_a = 8'hFF; d3_b = 8'h00; d3_cin = 1;
        for (int j = 0; j < 8; j++) begin
            tick();
            d3_in_valid = 0;
            if (j == 6) check("t6_d3_lat", d3_out_valid, 0);
            if (j == 7) check("t6_d3_res", {d3_out_valid, d3_cout, d3_sum}, {1'b1, 1'b1, 8'h00});
        end
        tick();

        // Test 5: random traffic with random backpressure on 32/4 and 8/8
        for (int c = 0; c < 10000; c++) begin
            d1_in_valid = 1'($urandom_range(0, 1));
            d1_a = $urandom; d1_b = $urandom; d1_cin = 1'($urandom_range(0, 1));
            d1_out_ready = ($urandom_range(0, 3) != 0);
            d3_in_valid = 1'($urandom_range(0, 1));
            d3_a = 8'($urandom_range(0, 255)); d3_b = 8'($urandom_range(0, 255));
            d3_cin = 1'($urandom_range(0, 1));
            d3_out_ready = ($urandom_range(0, 2) != 0);
            sb_step();
        end
        d1_in_valid = 0; d1_out_ready = 1;
        d3_in_valid = 0; d3_out_ready = 1;
        for (int c = 0; c < 12; c++) sb_step();
        check("t5_d1_drain", 64'(q1.size()), 0);
        check("t5_d3_drain", 64'(q3.size()), 0);
        check("t5_d1_idle", d1_out_valid, 0);
        check("t5_d3_idle", d3_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
